oc8051_ifetch: RTL and testbench

- Instruction fetch stage directly downstream of the internal program ROM (oc8051_rom).
- Per fetch request at a 16-bit PC, returns the three opcode bytes at PC, PC+1 and PC+2 to the decoder.
- Sources the bytes from the internal ROM when the address is internal and EA permits. Otherwise runs three byte-wide Wishbone reads to external program memory.
- Holds the assembled bytes with a valid/ready handshake.

---
 rtl/oc8051_ifetch_pkg.sv | 21 ++
 rtl/oc8051_ifetch_wb.sv | 72 +++++++
 rtl/oc8051_ifetch.sv | 194 +++++++++++++++++++
 tb/tb_oc8051_ifetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_ifetch_pkg.sv
// Shared types and constants for the oc8051 instruction fetch stage.
// The optional ack watchdog is enabled with OC8051_IFETCH_TIMEOUT_EN.
package oc8051_ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROM_WAIT,
        EXT0,
        EXT1,
        EXT2,
        HOLD
    } ifetch_state_t;

    localparam int         TIMEOUT_CYC_DEF = 255;
    localparam logic [7:0] NOP_BYTE        = 8'h00;

    function automatic logic is_ext_state(input ifetch_state_t s);
        return (s == EXT0) || (s == EXT1) || (s == EXT2);
    endfunction

endpackage

// File: rtl/oc8051_ifetch_wb.sv
// Wishbone byte-read master: owns cyc/stb/address and, when
// OC8051_IFETCH_TIMEOUT_EN is defined, the ack watchdog counter.
module oc8051_ifetch_wb
   import oc8051_ifetch_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_addr,
   input  logic        i_next,
   input  logic        i_stop,
   input  logic        wb_ack_i,
   output logic [15:0] wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        o_ack,
   output logic        o_timeout
);

   logic [15:0] r_adr;
   logic        r_cyc;
   logic        r_stb;

   // A stop always wins so an aborted or finished fetch frees the bus at once;
   // the address increment wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_adr <= 16'h0000;
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
      end else if (i_stop) begin
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
      end else if (i_start) begin
         r_adr <= i_addr;
         r_cyc <= 1'b1;
         r_stb <= 1'b1;
      end else if (i_next) begin
         r_adr <= r_adr + 16'd1;
      end
   end

   assign wb_adr_o = r_adr;
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign o_ack    = r_stb & wb_ack_i;

`ifdef OC8051_IFETCH_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC - 1);

   logic [7:0] r_wait_cnt;

   // Counts consecutive cycles of an unacknowledged strobe on one beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= 8'h00;
      end else if (!r_stb || wb_ack_i || i_start || i_next || i_stop) begin
         r_wait_cnt <= 8'h00;
      end else begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   assign o_timeout = r_stb & ~wb_ack_i & (r_wait_cnt == TIMEOUT_LIMIT);
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/oc8051_ifetch.sv
// oc8051 instruction fetch: three opcode bytes from internal ROM or Wishbone,
// held with a valid/ready handshake. Ack watchdog via OC8051_IFETCH_TIMEOUT_EN.
module oc8051_ifetch
   import oc8051_ifetch_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ea_in,
   input  logic [15:0] pc,
   input  logic        pc_req,
   input  logic        flush,
   output logic [15:0] rom_addr,
   input  logic        rom_ea_int,
   input  logic [7:0]  rom_data1,
   input  logic [7:0]  rom_data2,
   input  logic [7:0]  rom_data3,
   output logic [15:0] wb_adr_o,
   input  logic [7:0]  wb_dat_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic [7:0]  op1,
   output logic [7:0]  op2,
   output logic [7:0]  op3,
   output logic        op_valid,
   input  logic        op_ready,
   output logic        fetch_err
);

   ifetch_state_t r_state;
   logic [15:0]   r_fa;
   logic [15:0]   r_pend_pc;
   logic          r_pend_valid;
   logic          r_flushed;
   logic [7:0]    r_op1;
   logic [7:0]    r_op2;
   logic [7:0]    r_op3;
   logic          r_op_valid;
   logic          r_fetch_err;

   logic          w_in_ext;
   logic          w_use_rom;
   logic          w_discard;
   logic          w_launch;
   logic [15:0]   w_launch_pc;
   logic          w_ack;
   logic          w_timeout;
   logic          w_wb_start;
   logic          w_wb_next;
   logic          w_wb_stop;

   assign w_in_ext  = is_ext_state(r_state);
   assign w_use_rom = rom_ea_int & ea_in;
   assign w_discard = r_flushed | flush;

   // A new fetch may begin from IDLE (fresh or pending request), from HOLD on
   // accept or flush, or from ROM_WAIT when a branch flush carries a request.
   always_comb begin
      w_launch = 1'b0;
      case (r_state)
         IDLE:     w_launch = pc_req | r_pend_valid;
         ROM_WAIT: w_launch = flush & pc_req;
         HOLD:     w_launch = pc_req & (flush | op_ready);
         default:  w_launch = 1'b0;
      endcase
   end

   // A pending address from an aborted external fetch is only used when no
   // fresher request is present; the ROM sees it so the source check applies.
   assign w_launch_pc = (r_state == IDLE && !pc_req) ? r_pend_pc : pc;
   assign rom_addr    = (w_in_ext || (r_state == ROM_WAIT && !flush)) ? r_fa : w_launch_pc;

   assign w_wb_start = w_launch & ~w_use_rom;
   assign w_wb_next  = w_in_ext & w_ack & ~w_discard & (r_state != EXT2);
   assign w_wb_stop  = w_in_ext & ((w_ack & (w_discard | (r_state == EXT2))) | w_timeout);

   oc8051_ifetch_wb #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wb (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_wb_start),
      .i_addr    (w_launch_pc),
      .i_next    (w_wb_next),
      .i_stop    (w_wb_stop),
      .wb_ack_i  (wb_ack_i),
      .wb_adr_o  (wb_adr_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .o_ack     (w_ack),
      .o_timeout (w_timeout)
   );

   // Main fetch state machine: source select, handshake, flush and pending request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_fa         <= 16'h0000;
         r_pend_pc    <= 16'h0000;
         r_pend_valid <= 1'b0;
         r_flushed    <= 1'b0;
         r_op1        <= NOP_BYTE;
         r_op2        <= NOP_BYTE;
         r_op3        <= NOP_BYTE;
         r_op_valid   <= 1'b0;
         r_fetch_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, ROM_WAIT, HOLD: begin
               if (w_launch) begin
                  r_fa         <= w_launch_pc;
                  r_pend_valid <= 1'b0;
                  r_op_valid   <= 1'b0;
                  r_fetch_err  <= 1'b0;
                  r_state      <= w_use_rom ? ROM_WAIT : EXT0;
               end else if (r_state == ROM_WAIT) begin
                  if (flush) begin
                     r_state <= IDLE;
                  end else begin
                     r_op1      <= rom_data1;
                     r_op2      <= rom_data2;
                     r_op3      <= rom_data3;
                     r_op_valid <= 1'b1;
                     r_state    <= HOLD;
                  end
               end else if (r_state == HOLD && (flush || op_ready)) begin
                  r_op_valid  <= 1'b0;
                  r_fetch_err <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            EXT0, EXT1, EXT2: begin
               if (w_discard && pc_req) begin
                  r_pend_pc    <= pc;
                  r_pend_valid <= 1'b1;
               end
               if (w_ack || w_timeout) begin
                  r_flushed <= 1'b0;
                  if (w_discard) begin
                     r_state <= IDLE;
                  end else if (w_timeout) begin
                     case (r_state)
                        EXT0: begin
                           r_op1 <= NOP_BYTE;
                           r_op2 <= NOP_BYTE;
                           r_op3 <= NOP_BYTE;
                        end
                        EXT1: begin
                           r_op2 <= NOP_BYTE;
                           r_op3 <= NOP_BYTE;
                        end
                        default: r_op3 <= NOP_BYTE;
                     endcase
                     r_op_valid  <= 1'b1;
                     r_fetch_err <= 1'b1;
                     r_state     <= HOLD;
                  end else begin
                     case (r_state)
                        EXT0: begin
                           r_op1   <= wb_dat_i;
                           r_state <= EXT1;
                        end
                        EXT1: begin
                           r_op2   <= wb_dat_i;
                           r_state <= EXT2;
                        end
                        default: begin
                           r_op3      <= wb_dat_i;
                           r_op_valid <= 1'b1;
                           r_state    <= HOLD;
                        end
                     endcase
                  end
               end else if (flush) begin
                  r_flushed <= 1'b1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign op1       = r_op1;
   assign op2       = r_op2;
   assign op3       = r_op3;
   assign op_valid  = r_op_valid;
   assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed self-checking bench for oc8051_ifetch with a registered ROM model
// and a Wishbone slave model; the timeout steps need OC8051_IFETCH_TIMEOUT_EN.
module tb_oc8051_ifetch;

   logic        clk;
   logic        rst;
   logic        ea_in;
   logic [15:0] pc;
   logic        pc_req;
   logic        flush;
   logic [15:0] rom_addr;
   logic        rom_ea_int;
   logic [7:0]  rom_data1;
   logic [7:0]  rom_data2;
   logic [7:0]  rom_data3;
   logic [15:0] wb_adr_o;
   logic [7:0]  wb_dat_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic [7:0]  op1;
   logic [7:0]  op2;
   logic [7:0]  op3;
   logic        op_valid;
   logic        op_ready;
   logic        fetch_err;

   int          checks = 0;
   int          errors = 0;
   int          slaveWaits;
   bit          slaveDisable;
   int          waitCnt;
   int          acceptCount = 0;
   int          acceptBefore;
   logic [15:0] ackAddrs[$];
   logic [7:0]  romMem[0:255];

   oc8051_ifetch #(
      .TIMEOUT_CYC(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ea_in      (ea_in),
      .pc         (pc),
      .pc_req     (pc_req),
      .flush      (flush),
      .rom_addr   (rom_addr),
      .rom_ea_int (rom_ea_int),
      .rom_data1  (rom_data1),
      .rom_data2  (rom_data2),
      .rom_data3  (rom_data3),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_i   (wb_dat_i),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_ack_i   (wb_ack_i),
      .op1        (op1),
      .op2        (op2),
      .op3        (op3),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .fetch_err  (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External program memory contents seen by the Wishbone slave.
   function automatic logic [7:0] extByte(input logic [15:0] a);
      case (a)
         16'h0003: return 8'h7D;
         16'h0004: return 8'hAA;
         16'h0005: return 8'hE4;
         16'hFFFF: return 8'h11;
         16'h0000: return 8'h22;
         16'h0001: return 8'h33;
         16'h002E: return 8'h44;
         16'h002F: return 8'h55;
         16'h0030: return 8'h66;
         16'h0010: return 8'h77;
         16'h0011: return 8'h88;
         16'h0012: return 8'h99;
         default:  return a[7:0] ^ 8'hC3;
      endcase
   endfunction

   // Registered internal ROM: data valid one cycle after rom_addr.
   always @(posedge clk) begin
      logic [7:0] ra;
      ra = rom_addr[7:0];
      rom_data1 <= romMem[ra];
      rom_data2 <= romMem[8'(ra + 8'd1)];
      rom_data3 <= romMem[8'(ra + 8'd2)];
   end

   // Wishbone slave: acks each strobe after slaveWaits idle cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_i <= 1'b0;
         wb_dat_i <= 8'h00;
         waitCnt  <= 0;
      end else if (wb_cyc_o && wb_stb_o && !slaveDisable) begin
         if (wb_ack_i) begin
            wb_ack_i <= 1'b0;
            waitCnt  <= 0;
         end else if (waitCnt >= slaveWaits) begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= extByte(wb_adr_o);
         end else begin
            waitCnt <= waitCnt + 1;
         end
      end else begin
         wb_ack_i <= 1'b0;
         waitCnt  <= 0;
      end
   end

   // Records every acknowledged bus address and every accepted handshake.
   always @(posedge clk) begin
      if (!rst && wb_cyc_o && wb_stb_o && wb_ack_i) ackAddrs.push_back(wb_adr_o);
      if (!rst && op_valid && op_ready) acceptCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [15:0] pcVal,
                                input logic fl, input logic rdy);
      pc_req   = req;
      pc       = pcVal;
      flush    = fl;
      op_ready = rdy;
      @(negedge clk);
   endtask

   task automatic waitOpValid(input int maxCyc, input string tag);
      int n = 0;
      while (!op_valid && n < maxCyc) begin
         applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
         n++;
      end
      checkOutput(tag, 32'(op_valid), 32'd1);
   endtask

   task automatic checkAck(input string tag, input int idx, input logic [15:0] expected);
      logic [15:0] obs;
      obs = 16'hxxxx;
      if (idx < ackAddrs.size()) obs = ackAddrs[idx];
      checkOutput(tag, 32'(obs), 32'(expected));
   endtask

   task automatic checkOps(input string tag, input logic [23:0] expected);
      checkOutput(tag, {8'h00, op1, op2, op3}, {8'h00, expected});
   endtask

   task automatic acceptOps(input string tag);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput(tag, 32'(op_valid), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // Global watchdog so a hung bench cannot run forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach the end");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence following the test plan.
   initial begin
      for (int i = 0; i < 256; i++) romMem[i] = 8'(i) ^ 8'h5A;
      romMem[0] = 8'h02;
      romMem[1] = 8'h00;
      romMem[2] = 8'h2E;

      rst = 1'b1;
      pc_req = 1'b0;
      pc = 16'h0000;
      flush = 1'b0;
      op_ready = 1'b0;
      ea_in = 1'b1;
      rom_ea_int = 1'b1;
      slaveWaits = 0;
      slaveDisable = 1'b0;
      repeat (2) @(negedge clk);

      checkOutput("reset_op_valid", 32'(op_valid), 32'd0);
      checkOutput("reset_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
      checkOutput("reset_wb_adr", 32'(wb_adr_o), 32'h0000);
      checkOps("reset_ops", 24'h000000);
      checkOutput("reset_fetch_err", 32'(fetch_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
      checkOutput("rom_valid_after_1", 32'(op_valid), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("rom_valid_after_2", 32'(op_valid), 32'd1);
      checkOps("rom_ops", 24'h02002E);
      checkOutput("rom_no_bus", 32'(wb_cyc_o), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("rom_hold_valid", 32'(op_valid), 32'd1);
      checkOps("rom_hold_ops", 24'h02002E);
      acceptOps("rom_accept");

      ea_in = 1'b0;
      slaveWaits = 2;
      ackAddrs.delete();
      applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
      checkOutput("ext_stb_first", {30'b0, wb_cyc_o, wb_stb_o}, 32'd3);
      checkOutput("ext_adr_first", 32'(wb_adr_o), 32'h0003);
      waitOpValid(40, "ext_valid");
      checkOps("ext_ops", 24'h7DAAE4);
      checkOutput("ext_cyc_dropped", 32'(wb_cyc_o), 32'd0);
      checkOutput("ext_ack_count", ackAddrs.size(), 32'd3);
      checkAck("ext_ack0", 0, 16'h0003);
      checkAck("ext_ack1", 1, 16'h0004);
      checkAck("ext_ack2", 2, 16'h0005);
      acceptOps("ext_accept");

      slaveWaits = 0;
      ackAddrs.delete();
      applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
      waitOpValid(40, "wrap_valid");
      checkOps("wrap_ops", 24'h112233);
      checkAck("wrap_ack0", 0, 16'hFFFF);
      checkAck("wrap_ack1", 1, 16'h0000);
      checkAck("wrap_ack2", 2, 16'h0001);
      acceptOps("wrap_accept");

      slaveWaits = 3;
      ackAddrs.delete();
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
      for (int n = 0; n < 30 && ackAddrs.size() < 1; n++)
         applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("flush_beat0_acked", ackAddrs.size(), 32'd1);
      applyStimulus(1'b1, 16'h002E, 1'b1, 1'b0);
      checkOutput("flush_stb_held", 32'(wb_stb_o), 32'd1);
      checkOutput("flush_adr_held", 32'(wb_adr_o), 32'h0041);
      checkOutput("flush_no_valid", 32'(op_valid), 32'd0);
      waitOpValid(80, "flush_new_valid");
      checkOps("flush_new_ops", 24'h445566);
      checkOutput("flush_ack_count", ackAddrs.size(), 32'd5);
      checkAck("flush_ack1", 1, 16'h0041);
      checkAck("flush_ack2", 2, 16'h002E);
      checkAck("flush_ack4", 4, 16'h0030);

      ea_in = 1'b1;
      rom_ea_int = 1'b0;
      slaveWaits = 1;
      ackAddrs.delete();
      acceptBefore = acceptCount;
      applyStimulus(1'b1, 16'h0010, 1'b0, 1'b1);
      checkOutput("b2b_valid_cleared", 32'(op_valid), 32'd0);
      checkOutput("b2b_stb_no_gap", 32'(wb_stb_o), 32'd1);
      checkOutput("b2b_adr", 32'(wb_adr_o), 32'h0010);
      checkOutput("b2b_accept_once", acceptCount, acceptBefore + 1);
      waitOpValid(40, "b2b_valid");
      checkOps("b2b_ops", 24'h778899);
      checkOutput("b2b_accept_still_once", acceptCount, acceptBefore + 1);

      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("hold_flush_valid", 32'(op_valid), 32'd0);
      repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("hold_flush_idle", {30'b0, op_valid, wb_cyc_o}, 32'd0);

`ifdef OC8051_IFETCH_TIMEOUT_EN
      ea_in = 1'b0;
      slaveDisable = 1'b1;
      applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("tmo_not_yet", 32'(op_valid), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("tmo_valid", 32'(op_valid), 32'd1);
      checkOutput("tmo_err", 32'(fetch_err), 32'd1);
      checkOps("tmo_ops", 24'h000000);
      checkOutput("tmo_cyc_dropped", 32'(wb_cyc_o), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("tmo_err_cleared", {30'b0, fetch_err, op_valid}, 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      slaveDisable = 1'b0;
`endif

      ea_in = 1'b0;
      slaveWaits = 3;
      applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0);
      checkOutput("rstmid_cyc_up", 32'(wb_cyc_o), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("rstmid_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("rstmid_quiet", {30'b0, op_valid, wb_cyc_o}, 32'd0);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
